// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: valid/ready handshake with a 2-entry skid buffer and bubble-on-flush.
// Optional perf counters (stall_cnt, bubble_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  if (CTRL_W < 1 || DATA_W < 1 || CNT_W < 1) begin : g_bad_width
    $error("pipe_stage_reg: CTRL_W, DATA_W and CNT_W must all be at least 1");
  end

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush) begin
      // Data fields are left as-is; only the control fields are zeroed to form a bubble.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_ctrl_d  = '0;
    end else if (s_valid_q) begin
      if (out_ready) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!m_valid_q || out_ready) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = in_ctrl;
        m_data_d  = in_data;
      end else begin
        s_valid_d = 1'b1;
        s_ctrl_d  = in_ctrl;
        s_data_d  = in_data;
      end
    end else if (out_fire) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end
    // Ready is the registered complement of next skid occupancy, so out_ready never reaches in_ready combinationally.
    in_ready_d = !s_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_ctrl_q   <= '0;
      m_data_q   <= '0;
      s_valid_q  <= 1'b0;
      s_ctrl_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_ctrl_q   <= m_ctrl_d;
      m_data_q   <= m_data_d;
      s_valid_q  <= s_valid_d;
      s_ctrl_q   <= s_ctrl_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign out_data  = m_data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (m_valid_q && !out_ready) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!m_valid_q) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline boundary register for the pipelined core. It supersedes the fixed-field per-stage registers (D/E and similar).
- Carries a control field and a data field between two stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not create a combinational ready path.
- Flush inserts a bubble: the control field is zeroed, so no memory or register writes occur downstream.
- One instance per stage boundary (F/D, D/E, E/M, M/W).

Parameters:
CTRL_W, 16, width of control field (enables, ALU op, wb select); forced to zero on bubble
DATA_W, 160, width of data field (operands, imm, pc, pc+4, reg indices); held, not cleared, on bubble
CNT_W, 32, width of perf counters (only with PIPE_STAGE_PERF_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; kills all held entries
in_valid  input  1  upstream stage has an entry
in_ready  output  1  stage can accept; registered
in_ctrl  input  CTRL_W  upstream control field
in_data  input  DATA_W  upstream data field
out_valid  output  1  entry present for downstream
out_ready  input  1  downstream accepts
out_ctrl  output  CTRL_W  control field; all-zero whenever out_valid=0
out_data  output  DATA_W  data field of head entry
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0 (PIPE_STAGE_PERF_EN only)
bubble_cnt  output  CNT_W  cycles with out_valid=0 (PIPE_STAGE_PERF_EN only)

Behaviour:
- Storage: main reg (m_valid, m_ctrl, m_data) and skid reg (s_valid, s_ctrl, s_data).
- out_valid=m_valid; out_data=m_data; out_ctrl=m_valid?m_ctrl:0.
- in_ready = !s_valid, driven from a flop. No combinational path from out_ready to in_ready.
- Handshakes: in_fire=in_valid&in_ready; out_fire=m_valid&out_ready.
- Latency: 1 cycle. An entry accepted at edge N is on out_* after edge N; full throughput of 1 entry/cycle when out_ready=1.
- Per-edge update, priority order:
  1. rst_n=0 (async): m_valid=s_valid=0, m_ctrl=s_ctrl=0, m_data=s_data=0, in_ready=1, counters=0.
  2. flush=1: m_valid=s_valid=0, m_ctrl=s_ctrl=0, data regs unchanged, in_ready=1. in_fire on this cycle is discarded. out_fire on this cycle still counts as consumed by downstream.
  3. s_valid=1: if out_ready, then main<=skid and s_valid<=0 (in_ready=1 next cycle); else hold.
  4. s_valid=0, in_fire: if !m_valid or out_ready, main<=input (simultaneous in/out passes through with no bubble); else skid<=input and s_valid<=1.
  5. s_valid=0, no in_fire: if out_fire, m_valid<=0 and m_ctrl<=0.
- Ordering: strict FIFO. The skid entry is always younger than the main entry.
- Full: s_valid=1 means in_ready=0, and upstream must hold its entry.
- Empty: out_valid=0 means out_ctrl=0, which is a bubble.
- Reset mid-transfer: entries are lost. Outputs reach reset values immediately, without waiting for clk.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined: stall_cnt and bubble_cnt increment once per clk when their condition holds. They wrap modulo 2^CNT_W, reset to 0 on rst_n, and are unaffected by flush.
- Undefined: both ports and counter logic are absent from the module.

Test Plan:
1. Reset, then stream 4 entries (ctrl=16'h0001..0004) with out_ready=1 -> each appears 1 cycle later; in_ready stays 1; no gaps.
2. out_ready=0 with entries ctrl=A,B,C offered back-to-back -> A in main, B in skid, in_ready=0 after 2nd edge, C held. Then out_ready=1 -> out sequence A,B,C in order, with no loss or duplication.
3. Full (A main, B skid) then flush=1 with in_valid=1 (ctrl=C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears.
4. Assert rst_n=0 between edges while full -> out_valid=0, out_ctrl=0, in_ready=1 immediately (async); they stay so until rst_n rises.
5. Random in_valid/out_ready, 10k cycles, against a scoreboard FIFO -> order preserved; out_ctrl==0 whenever out_valid==0.
6. With PIPE_STAGE_PERF_EN: 5 cycles of out_valid=1, out_ready=0, then 3 empty cycles -> stall_cnt=5, bubble_cnt=3; a flush leaves both unchanged.
